// File: rtl/sprite_motion_sequencer.sv
// Frame-rate motion sequencer for four bouncing square sprites.
// One shared add/clamp datapath updates one axis of one sprite per cycle.
module sprite_motion_sequencer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        pause,
  input  logic [8:0]  size,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_idx,
  input  logic [10:0] cfg_x,
  input  logic [9:0]  cfg_y,
  input  logic [1:0]  cfg_dir,
  output logic [43:0] x_pos,
  output logic [39:0] y_pos,
  output logic        busy,
  output logic        done,
  output logic        bounce,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y, FIN} state_t;

  state_t      r_state, w_next;
  logic [10:0] r_x [4];
  logic [9:0]  r_y [4];
  logic [3:0]  r_dx, r_dy;
  logic [8:0]  r_size;
  logic [1:0]  r_cnt;
  logic        r_bounce, r_overrun;

  logic        w_start, w_is_y, w_dir, w_hi, w_lo, w_clamp, w_dir_new;
  logic [11:0] w_pos, w_step, w_lim, w_nxt;
  logic [10:0] w_res;

  assign w_start = (r_state == IDLE) && frame_tick && !pause;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = UPD_X;
      UPD_X:   w_next = UPD_Y;
      UPD_Y:   w_next = (r_cnt == 2'd3) ? FIN : UPD_X;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Positions carry one guard bit so underflow and overshoot compare correctly.
  always_comb begin
    w_is_y    = (r_state == UPD_Y);
    w_pos     = w_is_y ? {2'b00, r_y[r_cnt]} : {1'b0, r_x[r_cnt]};
    w_dir     = w_is_y ? r_dy[r_cnt] : r_dx[r_cnt];
    w_step    = (w_is_y ? 12'd6 : 12'd7) + {10'b0, r_cnt};
    w_lim     = (w_is_y ? 12'(V_RES) : 12'(H_RES)) - {3'b000, r_size};
    w_nxt     = w_dir ? (w_pos + w_step) : (w_pos - w_step);
    w_hi      = w_dir && ($signed(w_nxt) >= $signed(w_lim));
    w_lo      = !w_dir && ($signed(w_nxt) <= 12'sd0);
    w_clamp   = w_hi || w_lo;
    w_dir_new = w_hi ? 1'b0 : (w_lo ? 1'b1 : w_dir);
    w_res     = w_hi ? w_lim[10:0] : (w_lo ? '0 : w_nxt[10:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x[0] <= 11'd0;   r_x[1] <= 11'd120; r_x[2] <= 11'd100; r_x[3] <= 11'd40;
      r_y[0] <= 10'd300; r_y[1] <= 10'd300; r_y[2] <= 10'd400; r_y[3] <= 10'd200;
      r_dx      <= 4'b1110;
      r_dy      <= 4'b1101;
      r_size    <= 9'd80;
      r_cnt     <= '0;
      r_bounce  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_bounce <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cfg_we) begin
            r_x[cfg_idx]  <= cfg_x;
            r_y[cfg_idx]  <= cfg_y;
            r_dx[cfg_idx] <= cfg_dir[0];
            r_dy[cfg_idx] <= cfg_dir[1];
          end
          if (w_start) begin
            r_size <= size;
            r_cnt  <= '0;
          end
        end
        UPD_X: begin
          r_x[r_cnt]  <= w_res;
          r_dx[r_cnt] <= w_dir_new;
          r_bounce    <= w_clamp;
        end
        UPD_Y: begin
          r_y[r_cnt]  <= w_res[9:0];
          r_dy[r_cnt] <= w_dir_new;
          r_bounce    <= w_clamp;
          r_cnt       <= r_cnt + 2'd1;
        end
        default: ;
      endcase
      if (frame_tick && !pause && (r_state != IDLE))
        r_overrun <= 1'b1;
    end
  end

  always_comb begin
    x_pos = '0;
    y_pos = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      x_pos[11*i +: 11] = r_x[i];
      y_pos[10*i +: 10] = r_y[i];
    end
  end

  assign busy    = (r_state == UPD_X) || (r_state == UPD_Y);
  assign done    = (r_state == FIN);
  assign bounce  = r_bounce;
  assign overrun = r_overrun;

endmodule
